// File: rtl/alu_pkg.sv
// Shared definitions for the board-level ALU: default widths, opcodes and button bit indices.
package alu_pkg;

    localparam int NB_IN_DEF  = 8;
    localparam int NB_OUT_DEF = 8;
    localparam int NB_OP_DEF  = 6;
    localparam int NB_BTN     = 3;

    localparam int BTN_A  = 0;
    localparam int BTN_B  = 1;
    localparam int BTN_OP = 2;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

    // Only ADD and SUB can raise the signed-overflow flag.
    function automatic logic is_arith_op(input logic [NB_OP_DEF-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS-style ALU: (a, b, op) -> (result, signed overflow, zero).
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_IN = NB_IN_DEF,
    parameter int NB_OP = NB_OP_DEF
) (
    input  logic [NB_IN-1:0] a,
    input  logic [NB_IN-1:0] b,
    input  logic [NB_OP-1:0] op,
    output logic [NB_IN-1:0] result,
    output logic             carry,
    output logic             zero
);

    localparam int MSB = NB_IN - 1;
    localparam int SHW = $clog2(NB_IN);
    localparam logic [NB_IN-1:0] SHIFT_LIMIT = NB_IN[NB_IN-1:0];

    logic [NB_IN-1:0] sum;
    logic [NB_IN-1:0] diff;
    logic [SHW-1:0]   shamt;
    logic             over_shift;
    logic [NB_IN-1:0] sra_val;
    logic [NB_IN-1:0] srl_val;
    logic             add_ovf;
    logic             sub_ovf;

    assign sum  = a + b;
    assign diff = a - b;

    // Overflow is judged from sign bits only; the unsigned carry/borrow is deliberately dropped.
    assign add_ovf = (a[MSB] == b[MSB]) && (sum[MSB]  != a[MSB]);
    assign sub_ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    // Shift distances of NB_IN or more saturate to full sign fill / zero.
    assign shamt      = b[SHW-1:0];
    assign over_shift = (b >= SHIFT_LIMIT);
    assign sra_val    = $signed(a) >>> shamt;
    assign srl_val    = a >> shamt;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                carry  = add_ovf;
            end
            OP_SUB: begin
                result = diff;
                carry  = sub_ovf;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SRA: result = over_shift ? {NB_IN{a[MSB]}} : sra_val;
            OP_SRL: result = over_shift ? '0 : srl_val;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_top.sv
// Board wrapper: switch-bus operand/opcode registers loaded by buttons, ALU core, LED outputs.
// Define ALU_OUT_REG_EN to register the LED outputs (2-cycle button-to-LED latency).
module alu_top
    import alu_pkg::*;
#(
    parameter int NB_IN  = NB_IN_DEF,
    parameter int NB_OUT = NB_OUT_DEF,
    parameter int NB_OP  = NB_OP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NB_BTN-1:0] i_btn,
    input  logic [NB_IN-1:0]  i_sw_data,
    output logic [NB_OUT-1:0] o_leds_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [NB_IN-1:0] data_a;
    logic [NB_IN-1:0] data_b;
    logic [NB_OP-1:0] op;

    logic [NB_IN-1:0] core_result;
    logic             core_carry;
    logic             core_zero;

    // Level-sensitive loads; buttons are independent and may share one switch word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a <= '0;
            data_b <= '0;
            op     <= '0;
        end else begin
            if (i_btn[BTN_A]) begin
                data_a <= i_sw_data;
            end
            if (i_btn[BTN_B]) begin
                data_b <= i_sw_data;
            end
            if (i_btn[BTN_OP]) begin
                op <= i_sw_data[NB_OP-1:0];
            end
        end
    end

    generate
        if (NB_OP < NB_IN) begin : g_sw_upper
            logic unused_sw_upper;
            assign unused_sw_upper = ^i_sw_data[NB_IN-1:NB_OP];
        end
    endgenerate

    alu_core #(
        .NB_IN (NB_IN),
        .NB_OP (NB_OP)
    ) u_alu_core (
        .a      (data_a),
        .b      (data_b),
        .op     (op),
        .result (core_result),
        .carry  (core_carry),
        .zero   (core_zero)
    );

`ifdef ALU_OUT_REG_EN
    // Output registers reset to the same values the combinational path shows for all-zero inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_leds_result <= '0;
            o_carry       <= 1'b0;
            o_zero        <= 1'b1;
        end else begin
            o_leds_result <= core_result;
            o_carry       <= core_carry;
            o_zero        <= core_zero;
        end
    end
`else
    assign o_leds_result = core_result;
    assign o_carry       = core_carry;
    assign o_zero        = core_zero;
`endif

endmodule

// File: tb/tb_alu_top.sv
// Bench for alu_top: directed vector table, reset/multi-button sequences, random ops vs. an integer model.
module tb_alu_top;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] i_btn = 3'b000;
    logic [7:0] i_sw_data = 8'h00;
    logic [7:0] o_leds_result;
    logic       o_carry;
    logic       o_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] res;
        logic       c;
    } vec_t;

    vec_t vq[$];

    alu_top dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_btn         (i_btn),
        .i_sw_data     (i_sw_data),
        .o_leds_result (o_leds_result),
        .o_carry       (o_carry),
        .o_zero        (o_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [7:0] er, input logic ec);
        check8({name, "_result"}, o_leds_result, er);
        check1({name, "_carry"}, o_carry, ec);
        check1({name, "_zero"}, o_zero, (er == 8'h00));
    endtask

    // Reference: signed integer arithmetic straight from the opcode definitions.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] opc,
                                  output logic [7:0] r, output logic c);
        int sa, sb, s;
        sa = $signed(a);
        sb = $signed(b);
        r  = 8'h00;
        c  = 1'b0;
        case (opc)
            6'b100000: begin s = sa + sb; c = (s > 127) || (s < -128); r = s[7:0]; end
            6'b100010: begin s = sa - sb; c = (s > 127) || (s < -128); r = s[7:0]; end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b000011: begin
                if (b >= 8) r = (sa < 0) ? 8'hFF : 8'h00;
                else begin
                    s = sa;
                    for (int k = 0; k < int'(b); k++) s = (s - ((s % 2 + 2) % 2)) / 2;
                    r = s[7:0];
                end
            end
            6'b000010: begin
                if (b >= 8) r = 8'h00;
                else begin s = int'(a) / (1 << int'(b)); r = s[7:0]; end
            end
            default: begin r = 8'h00; c = 1'b0; end
        endcase
    endfunction

    // ---------------- drivers ----------------
    task automatic press(input logic [2:0] btn, input logic [7:0] sw);
        @(negedge clk);
        i_btn     = btn;
        i_sw_data = sw;
        @(negedge clk);
        i_btn     = 3'b000;
        i_sw_data = 8'($urandom);
    endtask

    task automatic load_op(input logic [5:0] opc);
        logic [1:0] junk;
        junk = 2'($urandom);
        press(3'b100, {junk, opc});
    endtask

    // Waiting one extra edge covers both the combinational and registered-output builds.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [5:0] opc);
        press(3'b001, a);
        press(3'b010, b);
        load_op(opc);
        settle();
    endtask

    function automatic vec_t mk(input string name, input logic [7:0] a, input logic [7:0] b,
                                input logic [5:0] opc, input logic [7:0] res, input logic c);
        vec_t v;
        v.name = name; v.a = a; v.b = b; v.op = opc; v.res = res; v.c = c;
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        logic [5:0] ops[10];
        logic [7:0] ra, rb, er;
        logic [5:0] rop;
        logic       ec;

        vq.push_back(mk("add_basic", 8'h01, 8'h02, OP_ADD, 8'h03, 1'b0));
        vq.push_back(mk("add_ovf_64_32", 8'h64, 8'h32, OP_ADD, 8'h96, 1'b1));
        vq.push_back(mk("add_ovf_7f_01", 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b1));
        vq.push_back(mk("add_ovf_80_ff", 8'h80, 8'hFF, OP_ADD, 8'h7F, 1'b1));
        vq.push_back(mk("sub_05_03", 8'h05, 8'h03, OP_SUB, 8'h02, 1'b0));
        vq.push_back(mk("sub_80_01", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1));
        vq.push_back(mk("sub_05_fb", 8'h05, 8'hFB, OP_SUB, 8'h0A, 1'b0));
        vq.push_back(mk("sub_7f_81", 8'h7F, 8'h81, OP_SUB, 8'hFE, 1'b1));
        vq.push_back(mk("sub_03_05", 8'h03, 8'h05, OP_SUB, 8'hFE, 1'b0));
        vq.push_back(mk("and", 8'h0F, 8'h03, OP_AND, 8'h03, 1'b0));
        vq.push_back(mk("or", 8'h0F, 8'h03, OP_OR, 8'h0F, 1'b0));
        vq.push_back(mk("xor", 8'h0F, 8'h03, OP_XOR, 8'h0C, 1'b0));
        vq.push_back(mk("nor", 8'h0F, 8'h03, OP_NOR, 8'hF0, 1'b0));
        vq.push_back(mk("sra_2", 8'hF0, 8'h02, OP_SRA, 8'hFC, 1'b0));
        vq.push_back(mk("srl_2", 8'hF0, 8'h02, OP_SRL, 8'h3C, 1'b0));
        vq.push_back(mk("srl_9", 8'hF0, 8'h09, OP_SRL, 8'h00, 1'b0));
        vq.push_back(mk("sra_9", 8'hF0, 8'h09, OP_SRA, 8'hFF, 1'b0));
        vq.push_back(mk("sra_8", 8'hF0, 8'h08, OP_SRA, 8'hFF, 1'b0));
        vq.push_back(mk("srl_8", 8'hF0, 8'h08, OP_SRL, 8'h00, 1'b0));
        vq.push_back(mk("srl_7", 8'hF0, 8'h07, OP_SRL, 8'h01, 1'b0));
        vq.push_back(mk("sra_7_pos", 8'h70, 8'h07, OP_SRA, 8'h00, 1'b0));
        vq.push_back(mk("sra_big", 8'h70, 8'hC0, OP_SRA, 8'h00, 1'b0));
        vq.push_back(mk("illegal_3f", 8'h0F, 8'h03, 6'b111111, 8'h00, 1'b0));
        vq.push_back(mk("illegal_00", 8'h7F, 8'h01, 6'b000000, 8'h00, 1'b0));

        // Reset state
        #1;
        check_out("reset_state", 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            run_op(vq[i].a, vq[i].b, vq[i].op);
            check_out(vq[i].name, vq[i].res, vq[i].c);
        end

        // Asynchronous reset mid-sequence, away from any clock edge
        run_op(8'h7F, 8'h01, OP_ADD);
        check_out("pre_reset_ovf", 8'h80, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 8'h00, 1'b0);

        // Button held through reset: load resumes on the first edge after release
        i_btn     = 3'b001;
        i_sw_data = 8'h42;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_wins", 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        i_btn = 3'b000;
        press(3'b010, 8'h01);
        load_op(OP_ADD);
        settle();
        check_out("load_after_reset", 8'h43, 1'b0);

        // Two buttons with one switch word load A and B together
        press(3'b011, 8'h05);
        load_op(OP_SUB);
        settle();
        check_out("multi_btn_sub", 8'h00, 1'b0);
        load_op(OP_ADD);
        settle();
        check_out("multi_btn_add", 8'h0A, 1'b0);

        // Random stimulus against the model
        ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL, 6'b000000, 6'b111111};
        for (int n = 0; n < 150; n++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 12)) : 8'($urandom);
            if ($urandom_range(0, 9) == 0) rop = 6'($urandom);
            else rop = ops[$urandom_range(0, 7)];
            model(ra, rb, rop, er, ec);
            run_op(ra, rb, rop);
            check_out($sformatf("rand%0d_op%b_%h_%h", n, rop, ra, rb), er, ec);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_top.md
# alu_top

Board-level wrapper around an 8-bit MIPS-style ALU. Operand A, operand B and the opcode are captured from a shared switch bus into three registers by three push buttons. The ALU result, a signed-overflow flag and a zero flag drive the LEDs. It sits directly under the FPGA pin constraints, with no other logic between it and the board I/O.

## Interface
- NB_IN, 8: operand width and switch-bus width.
- NB_OUT, 8: result width. Must equal NB_IN.
- NB_OP, 6: opcode width. Must satisfy NB_OP <= NB_IN.
- clk  input  1  system clock; all registers are rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_btn  input  3  load strobes: bit0 loads A, bit1 loads B, bit2 loads the opcode.
- i_sw_data  input  NB_IN  shared switch data bus.
- o_leds_result  output  NB_OUT  ALU result.
- o_carry  output  1  signed overflow for ADD/SUB; 0 for all other opcodes.
- o_zero  output  1  high when o_leds_result == 0.

## Operation
- Registers:
  - data_a[NB_IN-1:0] and data_b[NB_IN-1:0].
  - op[NB_OP-1:0], loaded from i_sw_data[NB_OP-1:0]; the upper switch bits are ignored.
  - All three reset to 0.
- Loads:
  - Each register loads on every rising edge while its button bit is 1. Loading is level-sensitive; there is no edge detection or debounce in this block.
  - Button bits are independent. Several asserted together load the same i_sw_data into each selected register in the same cycle.
- Opcodes, with A = data_a and B = data_b, both treated as two's-complement:
  - ADD 100000: A+B.
  - SUB 100010: A-B.
  - AND 100100: A&B.
  - OR 100101: A|B.
  - XOR 100110: A^B.
  - NOR 100111: ~(A|B).
  - SRA 000011: A arithmetic-shifted right by B. If B >= NB_IN, the result is all sign bits.
  - SRL 000010: A logically shifted right by B. If B >= NB_IN, the result is 0.
  - Any other opcode, including the reset value 000000: result 0, carry 0.
- Result width: NB_IN bits, with wrap-around and no saturation.
- o_carry:
  - ADD: set when A and B have the same sign and the result's sign differs.
  - SUB: set when A and B have different signs and the result's sign differs from A's.
  - Unsigned carry or borrow is not reported, so 3-5 gives 0xFE with o_carry=0.
- o_zero = (result == 0), valid for every opcode.

## Timing
- Default build: the ALU is combinational from the three registers. Outputs reflect a new operand or opcode right after the rising edge that loads it (1-cycle latency from button to LEDs).
- Reset asserted: registers clear immediately, independent of clk. Outputs become o_leds_result=0, o_carry=0, o_zero=1.
- Reset deasserted: loads take effect from the next rising edge.
- Reset during a button press: reset wins. The load resumes on the first edge after release if the button is still held.

## Configuration
- ALU_OUT_REG_EN:
  - Defined: o_leds_result, o_carry and o_zero come from output registers. Latency from button to LEDs is 2 cycles. The output registers reset to 0/0/1 asynchronously.
  - Undefined (default): combinational outputs as described in Timing.

## Structure
- Package alu_pkg holds:
  - the opcode localparams OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR;
  - the default widths;
  - the button bit indices BTN_A=0, BTN_B=1, BTN_OP=2.
- Sub-module alu_core: purely combinational (A, B, op) -> (result, carry, zero).
- alu_top contains the input registers, the optional output registers and the alu_core instance.

## Test plan
- Reset, then load 01/02/ADD -> 03, carry 0, zero 0.
- ADD overflow cases, each -> carry 1:
  - 64+32 -> 96;
  - 7F+01 -> 80;
  - 80+FF -> 7F.
- SUB cases:
  - 05-03 -> 02, carry 0;
  - 80-01 -> 7F, carry 1;
  - 05-FB -> 0A, carry 0;
  - 7F-81 -> FE, carry 1;
  - 03-05 -> FE, carry 0.
- Logic with A=0F, B=03:
  - AND -> 03;
  - OR -> 0F;
  - XOR -> 0C;
  - NOR -> F0.
- Shifts with A=F0:
  - SRA by 02 -> FC;
  - SRL by 02 -> 3C;
  - SRL by 09 -> 00, zero 1;
  - SRA by 09 -> FF.
- Corner cases:
  - illegal opcode 111111 -> result 00, zero 1, carry 0;
  - asserting rst_n low mid-sequence clears outputs asynchronously;
  - i_btn=011 with sw=05 loads A=B=05, so SUB -> 00 with zero 1.
